// File: rtl/sfu_v2.sv
// Special-function unit: per-lane psum accumulation (WS) or pass-through (OS), optional ReLU.
// Define SFU_SAT_EN to saturate the WS lane add on signed overflow instead of wrapping.
module sfu_v2 #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int addr_w  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode_i,
  input  logic                     relu_en_i,
  input  logic                     in_valid_i,
  input  logic                     in_first_i,
  input  logic                     in_last_i,
  input  logic [addr_w-1:0]        in_addr_i,
  input  logic                     clear_i,
  input  logic [col*psum_bw-1:0]   psum_in,
  output logic                     out_valid_o,
  output logic [addr_w-1:0]        out_addr_o,
  output logic [col*psum_bw-1:0]   psum_out,
  output logic [col-1:0]           ovf_o
);

  localparam logic [addr_w:0] depth_lim = (addr_w+1)'(depth);

  logic [col*psum_bw-1:0] acc [depth];
  logic [col*psum_bw-1:0] acc_rd;
  logic [col*psum_bw-1:0] sum_vec;
  logic [col*psum_bw-1:0] res_vec;
  logic [col-1:0]         ovf_vec;
  logic                   addr_ok;
  logic                   beat;
  logic                   ws_beat;
  logic                   emit;

  // Clear wins over a coincident beat; out-of-range addresses are ignored entirely.
  assign addr_ok = {1'b0, in_addr_i} < depth_lim;
  assign beat    = in_valid_i && addr_ok && !clear_i;
  assign ws_beat = beat && !mode_i;
  assign emit    = beat && (mode_i || in_last_i);
  assign acc_rd  = acc[in_addr_i];

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic [psum_bw-1:0] base_l;
    logic [psum_bw-1:0] in_l;
    logic [psum_bw-1:0] raw_l;
    logic [psum_bw-1:0] sum_l;
    logic [psum_bw-1:0] sel_l;
    logic               ovf_l;

    assign in_l   = psum_in[k*psum_bw +: psum_bw];
    assign base_l = in_first_i ? '0 : acc_rd[k*psum_bw +: psum_bw];
    assign raw_l  = base_l + in_l;
    assign ovf_l  = (base_l[psum_bw-1] == in_l[psum_bw-1]) &&
                    (raw_l[psum_bw-1] != base_l[psum_bw-1]);
`ifdef SFU_SAT_EN
    localparam logic [psum_bw-1:0] sat_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] sat_min = {1'b1, {(psum_bw-1){1'b0}}};
    assign sum_l  = ovf_l ? (base_l[psum_bw-1] ? sat_min : sat_max) : raw_l;
`else
    assign sum_l  = raw_l;
`endif
    assign sel_l  = mode_i ? in_l : sum_l;
    assign sum_vec[k*psum_bw +: psum_bw] = sum_l;
    assign res_vec[k*psum_bw +: psum_bw] = (relu_en_i && sel_l[psum_bw-1]) ? '0 : sel_l;
    assign ovf_vec[k] = ovf_l;
  end

  // A final WS beat leaves its entry zeroed, ready for the next tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) acc[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < depth; i++) acc[i] <= '0;
    end else if (ws_beat) begin
      acc[in_addr_i] <= in_last_i ? '0 : sum_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      psum_out    <= '0;
      ovf_o       <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      ovf_o       <= '0;
    end else begin
      out_valid_o <= emit;
      if (emit) begin
        out_addr_o <= in_addr_i;
        psum_out   <= res_vec;
      end
      if (ws_beat) ovf_o <= ovf_o | ovf_vec;
    end
  end

endmodule

// File: tb/tb_sfu_v2.sv
// Scoreboard bench for sfu_v2: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_sfu_v2;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int AW  = 4;
  localparam int W   = COL * PB;

`ifdef SFU_SAT_EN
  localparam logic [PB-1:0] OVF_POS_EXP = 16'h7FFF;
  localparam logic [PB-1:0] OVF_NEG_EXP = 16'h8000;
`else
  localparam logic [PB-1:0] OVF_POS_EXP = 16'h8000;
  localparam logic [PB-1:0] OVF_NEG_EXP = 16'h7FFF;
`endif

  logic          clk;
  logic          reset;
  logic          mode_i;
  logic          relu_en_i;
  logic          in_valid_i;
  logic          in_first_i;
  logic          in_last_i;
  logic [AW-1:0] in_addr_i;
  logic          clear_i;
  logic [W-1:0]  psum_in;
  logic          out_valid_o;
  logic [AW-1:0] out_addr_o;
  logic [W-1:0]  psum_out;
  logic [COL-1:0] ovf_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  sfu_v2 #(.psum_bw(PB), .col(COL), .depth(16), .addr_w(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_i     (mode_i),
    .relu_en_i  (relu_en_i),
    .in_valid_i (in_valid_i),
    .in_first_i (in_first_i),
    .in_last_i  (in_last_i),
    .in_addr_i  (in_addr_i),
    .clear_i    (clear_i),
    .psum_in    (psum_in),
    .out_valid_o(out_valid_o),
    .out_addr_o (out_addr_o),
    .psum_out   (psum_out),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [PB-1:0] l0, input logic [PB-1:0] l1);
    logic [W-1:0] v;
    v = '0;
    v[PB-1:0]    = l0;
    v[2*PB-1:PB] = l1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One beat lasting one clock; inputs change 1 time unit after the active edge.
  task automatic applyStimulus(input logic m, input logic r, input logic f, input logic l,
                               input logic [AW-1:0] a, input logic [W-1:0] d, input logic clr,
                               input logic emit, input logic [W-1:0] e);
    exp_t x;
    mode_i = m; relu_en_i = r; in_first_i = f; in_last_i = l;
    in_addr_i = a; psum_in = d; clear_i = clr; in_valid_i = 1'b1;
    if (emit) begin
      x.addr = a;
      x.data = e;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_out: got addr %0d data %h, expected no beat", out_addr_o, psum_out);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        checkOutput("out_addr", W'(out_addr_o), W'(x.addr));
        checkOutput("psum_out", psum_out, x.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; mode_i = 1'b0; relu_en_i = 1'b0; in_valid_i = 1'b0;
    in_first_i = 1'b0; in_last_i = 1'b0; in_addr_i = '0; clear_i = 1'b0; psum_in = '0;
    idleCycles(2);
    checkOutput("rst_valid", W'(out_valid_o), '0);
    checkOutput("rst_addr",  W'(out_addr_o),  '0);
    checkOutput("rst_psum",  psum_out,        '0);
    checkOutput("rst_ovf",   W'(ovf_o),       '0);
    reset = 1'b0;
    idleCycles(1);

    // WS accumulate at addr 3: lane0 5+7-2=10, lane1 1+2+3=6
    applyStimulus(0, 0, 1, 0, 4'd3, mk(16'd5, 16'd1), 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 4'd3, mk(16'd7, 16'd2), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd3, mk(16'hFFFE, 16'd3), 0, 1, mk(16'd10, 16'd6));
    idleCycles(1);
    applyStimulus(0, 0, 0, 1, 4'd3, '0, 0, 1, '0);
    idleCycles(1);

    // Interleaved addr 1 / addr 2, back to back
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, i == 0, i == 3, 4'd1, mk(16'd1, 16'd0), 0, i == 3, mk(16'd4, 16'd0));
      applyStimulus(0, 0, i == 0, i == 3, 4'd2, mk(16'd1, 16'd0), 0, i == 3, mk(16'd4, 16'd0));
    end
    idleCycles(1);

    // Total -9 with and without ReLU
    applyStimulus(0, 1, 1, 0, 4'd4, mk(16'hFFFC, 16'd0), 0, 0, '0);
    applyStimulus(0, 1, 0, 1, 4'd4, mk(16'hFFFB, 16'd0), 0, 1, mk(16'd0, 16'd0));
    applyStimulus(0, 0, 1, 0, 4'd4, mk(16'hFFFC, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd4, mk(16'hFFFB, 16'd0), 0, 1, mk(16'hFFF7, 16'd0));
    idleCycles(1);

    // OS pass-through with ReLU leaves a pending WS entry at addr 7 intact
    applyStimulus(0, 0, 1, 0, 4'd7, mk(16'd20, 16'd0), 0, 0, '0);
    applyStimulus(1, 1, 1, 0, 4'd7, mk(16'hFFFD, 16'd100), 0, 1, mk(16'd0, 16'd100));
    idleCycles(2);
    checkOutput("hold_valid", W'(out_valid_o), '0);
    checkOutput("hold_addr",  W'(out_addr_o),  W'(4'd7));
    checkOutput("hold_psum",  psum_out,        mk(16'd0, 16'd100));
    applyStimulus(0, 0, 0, 1, 4'd7, mk(16'd1, 16'd0), 0, 1, mk(16'd21, 16'd0));
    idleCycles(1);

    // Signed overflow, positive then negative
    applyStimulus(0, 0, 1, 0, 4'd8, mk(16'h7FFF, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd8, mk(16'h0001, 16'd0), 0, 1, mk(OVF_POS_EXP, 16'd0));
    idleCycles(1);
    checkOutput("ovf_set", W'(ovf_o), W'(8'h01));
    applyStimulus(0, 0, 1, 0, 4'd9, mk(16'h8000, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd9, mk(16'hFFFF, 16'd0), 0, 1, mk(OVF_NEG_EXP, 16'd0));
    idleCycles(1);

    // Clear drops a coincident final beat and wipes acc and ovf
    applyStimulus(0, 0, 1, 0, 4'd5, mk(16'd10, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 4'd5, mk(16'd20, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd5, mk(16'd1, 16'd0), 1, 0, '0);
    checkOutput("clr_ovf", W'(ovf_o), '0);
    applyStimulus(0, 0, 0, 1, 4'd5, mk(16'd4, 16'd0), 0, 1, mk(16'd4, 16'd0));
    applyStimulus(0, 0, 1, 1, 4'd5, mk(16'd4, 16'd0), 0, 1, mk(16'd4, 16'd0));
    idleCycles(1);

    // Asynchronous reset mid-accumulation
    applyStimulus(0, 0, 1, 0, 4'd8, mk(16'h7FFF, 16'd0), 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 4'd8, mk(16'h0001, 16'd0), 0, 1, mk(OVF_POS_EXP, 16'd0));
    applyStimulus(0, 0, 1, 0, 4'd6, mk(16'd50, 16'd0), 0, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", W'(out_valid_o), '0);
    checkOutput("arst_addr",  W'(out_addr_o),  '0);
    checkOutput("arst_psum",  psum_out,        '0);
    checkOutput("arst_ovf",   W'(ovf_o),       '0);
    @(negedge clk);
    reset = 1'b0;
    idleCycles(1);
    applyStimulus(0, 0, 0, 1, 4'd6, mk(16'd1, 16'd0), 0, 1, mk(16'd1, 16'd0));
    idleCycles(3);

    checkOutput("pending", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfu_v2.md
Name: sfu_v2

Overview:
- Parametrised special-function unit between the PE-array psum outputs and the output SRAM.
- Holds a bank of `depth` accumulator entries per column. In weight-stationary (WS) mode it accumulates tiled partial sums per output address; in output-stationary (OS) mode it passes array results straight through.
- Optional ReLU is applied on final results, which are emitted with a valid strobe and address.

Parameters:
- psum_bw, 16, width of one column psum (two's complement)
- col, 8, number of columns / lanes
- depth, 16, accumulator entries per lane
- addr_w, 4, entry address width; must equal clog2(depth)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mode_i  in  1  1 = OS (pass-through), 0 = WS (accumulate)
- relu_en_i  in  1  1 = apply ReLU to emitted results
- in_valid_i  in  1  psum_in beat valid
- in_first_i  in  1  beat is the first contribution for in_addr_i; discard old entry content
- in_last_i  in  1  beat is the final contribution; emit result
- in_addr_i  in  addr_w  accumulator entry address
- clear_i  in  1  synchronous clear of all entries
- psum_in  in  col*psum_bw  lane k at bits [(k+1)*psum_bw-1 : k*psum_bw]
- out_valid_o  out  1  result beat valid
- out_addr_o  out  addr_w  entry address of the result
- psum_out  out  col*psum_bw  result, same lane packing
- ovf_o  out  col  sticky per-lane overflow flag, cleared by clear_i

Behaviour:
- Reset (async) state:
  - acc array = 0.
  - out_valid_o = 0, out_addr_o = 0, psum_out = 0, ovf_o = 0.
- Outputs are registered: a beat presented at edge N produces its result at edge N+1.
- out_valid_o is a single-cycle pulse per emitting beat. There is no backpressure; the consumer always accepts.
- WS mode, beat with in_valid_i = 1:
  - base = in_first_i ? 0 : acc[in_addr_i]
  - sum = base + psum_in, computed per lane at psum_bw bits
  - If in_last_i = 0: acc[in_addr_i] <= sum; no output.
  - If in_last_i = 1: emit sum (after optional ReLU) at in_addr_i, and write acc[in_addr_i] <= 0.
  - in_first_i together with in_last_i emits psum_in directly.
- OS mode, beat with in_valid_i = 1:
  - Emits psum_in (after optional ReLU) at in_addr_i regardless of in_first_i / in_last_i.
  - acc is untouched.
- ReLU: a lane whose MSB is 1 outputs 0; otherwise the value passes unchanged. relu_en_i is sampled with the beat.
- Back-to-back beats to the same address:
  - acc is read combinationally and written at the edge, so beat N+1 sees beat N's update.
  - No bubbles are required.
- in_valid_i = 0: no acc change, out_valid_o <= 0, psum_out and out_addr_o hold their last values.
- Overflow:
  - Signed overflow of any lane add sets that lane's ovf_o bit (sticky).
  - Without SFU_SAT_EN the sum wraps modulo 2^psum_bw.
- clear_i = 1: all acc entries <= 0, ovf_o <= 0, out_valid_o <= 0. A beat in the same cycle is dropped (clear has priority).
- mode_i may change only between beats. The mode is sampled per beat, and acc content persists across mode switches.
- in_addr_i >= depth (non-power-of-two depth): the beat is ignored, with no acc write and no output.
- Reset mid-accumulation discards all partial sums.

Optional Feature:
- Macro SFU_SAT_EN.
- When defined: the WS lane add saturates to +(2^(psum_bw-1)-1) or -2^(psum_bw-1) on signed overflow; ovf_o still sets.
- When undefined: the add wraps.
- OS pass-through is unaffected either way.

Test Plan:
- WS, addr 3, col lane 0 beats +5 (first), +7, -2 (last), relu_en = 0 -> one out_valid_o pulse, out_addr_o = 3, lane 0 = 10; acc[3] reads 0 afterwards.
- WS interleave addr 1 / addr 2, each receiving 4 beats of +1 (first on beat 1, last on beat 4), alternating every cycle -> two results of 4 at addrs 1 then 2, each one cycle after its last beat.
- WS total -9 with relu_en = 1 -> lane output 0; the same sequence with relu_en = 0 -> 16'hFFF7.
- OS, relu_en = 1, lanes {-3, 100} at addr 7 -> next cycle out_valid_o = 1, lanes {0, 100}, out_addr_o = 7; acc unchanged.
- Overflow: 16'h7FFF (first) + 16'h0001 (last) -> 16'h8000 and ovf_o[0] = 1 without SFU_SAT_EN; 16'h7FFF with SFU_SAT_EN.
- Assert clear_i after two non-last beats at addr 5, then a first+last beat of +4 -> result 4, ovf_o = 0. Assert reset mid-sequence -> all outputs return to 0 asynchronously.
